// File: rtl/shift_sequencer.sv
// Iterative 16-bit shifter: one power-of-two stage per clock with a start/busy/done handshake.
// Optional early exit when remaining count bits are zero: define SHIFT_SEQ_EARLY_EXIT_EN.
module shift_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Out
);

    localparam int unsigned       IDX_W    = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CNT_W - 1);

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_STAGE = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] stage_amt;

    // Single shift stage; rotates use a doubled operand so wrapped bits fall in naturally.
    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] d,
        input logic [CNT_W-1:0] amt,
        input logic [1:0]       op
    );
        logic [2*WIDTH-1:0] lft;
        logic [2*WIDTH-1:0] rgt;
        logic [WIDTH-1:0]   res;
        lft = {d, d} << amt;
        rgt = {d, d} >> amt;
        case (op)
            OP_ROL:  res = lft[2*WIDTH-1:WIDTH];
            OP_SLL:  res = d << amt;
            OP_ROR:  res = rgt[WIDTH-1:0];
            OP_SRL:  res = d >> amt;
            default: res = d;
        endcase
        return res;
    endfunction

    assign stage_amt = CNT_W'(1) << idx_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        op_d    = op_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = Op;
                    cnt_d   = Cnt;
                    data_d  = In;
                    idx_d   = '0;
                    state_d = S_STAGE;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
                    if (Cnt == '0) begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_STAGE: begin
                if (cnt_q[idx_q]) begin
                    data_d = shift_stage(data_q, stage_amt, op_q);
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
                else if (((cnt_q >> idx_q) >> 1) == '0) begin
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Out  = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer against a whole-amount shift model.
// Latency expectations follow SHIFT_SEQ_EARLY_EXIT_EN when it is defined for the build.
module tb_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  Op;
    logic [15:0] In;
    logic [3:0]  Cnt;
    logic        busy;
    logic        done;
    logic [15:0] Out;

    int n_checks = 0;
    int n_fail   = 0;

    shift_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Op    (Op),
        .In    (In),
        .Cnt   (Cnt),
        .busy  (busy),
        .done  (done),
        .Out   (Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Whole-amount shift computed in one step from the operation's definition.
    function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] x, input int c);
        int unsigned xi;
        int unsigned r;
        xi = 32'(x);
        if (c == 0) return x;
        case (op)
            2'b00:   r = (xi << c) | (xi >> (16 - c));
            2'b01:   r = xi << c;
            2'b10:   r = (xi >> c) | (xi << (16 - c));
            default: r = xi >> c;
        endcase
        return 16'(r & 32'hFFFF);
    endfunction

    // Edges after the accepting edge until done is visible.
    function automatic int ref_lat(input int c);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        int h;
        h = -1;
        for (int b = 0; b < 4; b++) if (((c >> b) & 1) != 0) h = b;
        return h + 1;
`else
        return (c < 0) ? 0 : 4;
`endif
    endfunction

    // Present an op, let one edge accept it, then scramble inputs to show they are not re-read.
    task automatic launch(input logic [1:0] op, input logic [15:0] din, input logic [3:0] c);
        Op    = op;
        In    = din;
        Cnt   = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        Op    = 2'($urandom);
        In    = 16'($urandom);
        Cnt   = 4'($urandom);
    endtask

    task automatic wait_done(input string tag, input logic [15:0] exp_out, input int exp_lat);
        int k;
        k = 0;
        while (!done && k < 12) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq({tag, "_lat"},  32'(k),    32'(exp_lat));
        check_eq({tag, "_out"},  32'(Out),  32'(exp_out));
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        check_eq({tag, "_done_clr"}, 32'(done), 32'd0);
        check_eq({tag, "_idle"},     32'(busy), 32'd0);
        check_eq({tag, "_hold"},     32'(Out),  32'(exp_out));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        int first;
        logic [15:0] out_at;
        logic [1:0]  rop;
        logic [15:0] rin;
        logic [3:0]  rc;

        rst = 1'b1; start = 1'b0; Op = '0; In = '0; Cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_out",  32'(Out),  32'd0);
        @(posedge clk); #1;
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_out",  32'(Out),  32'd0);

        launch(2'b01, 16'h0001, 4'd15);
        wait_done("sll15", 16'h8000, ref_lat(15));
        launch(2'b00, 16'h8001, 4'd4);
        wait_done("rol4", 16'h0018, ref_lat(4));
        launch(2'b10, 16'h0001, 4'd1);
        wait_done("ror1", 16'h8000, ref_lat(1));

        // A start arriving while busy must be dropped.
        launch(2'b11, 16'h8000, 4'd1);
        ndone = 0; first = -1; out_at = '0;
        for (int c = 0; c < 10; c++) begin
            if (c == 1) begin start = 1'b1; In = 16'hFFFF; Cnt = 4'd8; end
            if (c == 2) start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) begin first = c; out_at = Out; end
            end
            @(posedge clk); #1;
        end
        check_eq("ign_ndone", 32'(ndone),  32'd1);
        check_eq("ign_lat",   32'(first),  32'(ref_lat(1)));
        check_eq("ign_out",   32'(out_at), 32'h4000);

        // Reset in the middle of an operation aborts it without a done pulse.
        launch(2'b11, 16'hF000, 4'd3);
        @(posedge clk); #1;
        check_eq("abort_pre_done", 32'(done), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_out",  32'(Out),  32'd0);
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        check_eq("abort_no_done", 32'(ndone), 32'd0);
        launch(2'b11, 16'hF000, 4'd3);
        wait_done("srl3", 16'h1E00, ref_lat(3));

        launch(2'b01, 16'h1234, 4'd0);
        wait_done("cnt0", 16'h1234, ref_lat(0));
        launch(2'b01, 16'h0003, 4'd2);
        wait_done("sll2", 16'h000C, ref_lat(2));

        // Start held high: back-to-back operations, period is latency plus two.
        Op = 2'b01; In = 16'h0001; Cnt = 4'd15; start = 1'b1;
        ndone = 0; first = -1; out_at = '0;
        for (int c = 0; c < 18; c++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (first < 0) first = c;
                out_at = Out;
            end
        end
        start = 1'b0;
        check_eq("held_ndone", 32'(ndone),  32'd3);
        check_eq("held_first", 32'(first),  32'(ref_lat(15)));
        check_eq("held_out",   32'(out_at), 32'h8000);
        repeat (8) @(posedge clk);
        #1;
        check_eq("held_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            rin = 16'($urandom);
            rc  = 4'($urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            launch(rop, rin, rc);
            wait_done($sformatf("rnd%0d_op%0d_c%0d", i, rop, rc), ref_shift(rop, rin, int'(rc)), ref_lat(int'(rc)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
